// File: rtl/pc_fetch_unit.sv
// Program counter / fetch unit: IDLE/RUN/HALT sequencing, spc/je/jne target registers, retire counters.
// Optional taken-jump counter built only when PC_FETCH_BRANCH_COUNT_EN is defined.
module pc_fetch_unit #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned OFFSET_AMT = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic             JumpEqual,
    input  logic             JumpNotEqual,
    input  logic             OffsetEn,
    input  logic [1:0]       PCRegSelect,
    input  logic             ZeroFlag,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstCount,
    output logic [CNT_W-1:0] TakenCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [PC_W-1:0]           pc_q, pc_d;
    logic [2:0][PC_W-1:0]      pcreg_q, pcreg_d;
    logic [CNT_W-1:0]          inst_q, inst_d;
    logic                      running_q, done_q;

    logic                      clear_c;
    logic                      taken_c;
    logic                      save_c;
    logic [PC_W-1:0]           target_c;
    logic [PC_W-1:0]           pc_inc_c;
    logic [PC_W-1:0]           save_val_c;

    // Jump decode; both je and jne high is treated as unconditional
    always_comb begin
        target_c = '0;
        case (PCRegSelect)
            2'b01:   target_c = pcreg_q[0];
            2'b10:   target_c = pcreg_q[1];
            2'b11:   target_c = pcreg_q[2];
            default: target_c = '0;
        endcase
        taken_c    = (PCRegSelect != 2'b00) &&
                     ((JumpEqual & ZeroFlag) | (JumpNotEqual & ~ZeroFlag) |
                      (JumpEqual & JumpNotEqual));
        save_c     = (PCRegSelect != 2'b00) && !JumpEqual && !JumpNotEqual;
        pc_inc_c   = pc_q + PC_W'(1);
        save_val_c = OffsetEn ? (pc_q + PC_W'(OFFSET_AMT)) : pc_inc_c;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pcreg_d = pcreg_q;
        inst_d  = inst_q;
        clear_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                clear_c = 1'b1;
                if (!Start) state_d = S_RUN;
            end
            S_RUN: begin
                if (Start) begin
                    state_d = S_IDLE;
                    clear_c = 1'b1;
                end else begin
                    if (inst_q != '1) inst_d = inst_q + CNT_W'(1);
                    if (Ack) begin
                        state_d = S_HALT;
                    end else if (taken_c) begin
                        pc_d = target_c;
                    end else begin
                        pc_d = pc_inc_c;
                        if (save_c) begin
                            case (PCRegSelect)
                                2'b01:   pcreg_d[0] = save_val_c;
                                2'b10:   pcreg_d[1] = save_val_c;
                                2'b11:   pcreg_d[2] = save_val_c;
                                default: pcreg_d    = pcreg_q;
                            endcase
                        end
                    end
                end
            end
            S_HALT: begin
                if (Start) begin
                    state_d = S_IDLE;
                    clear_c = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                clear_c = 1'b1;
            end
        endcase
        if (clear_c) begin
            pc_d    = '0;
            pcreg_d = '0;
            inst_d  = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            pcreg_q   <= '0;
            inst_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pcreg_q   <= pcreg_d;
            inst_q    <= inst_d;
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_HALT);
        end
    end

    assign ProgCtr   = pc_q;
    assign Running   = running_q;
    assign Done      = done_q;
    assign InstCount = inst_q;

`ifdef PC_FETCH_BRANCH_COUNT_EN
    logic [CNT_W-1:0] taken_q, taken_d;
    logic             taken_retire_c;

    // Counts jumps actually redirecting the PC; saturating
    always_comb begin
        taken_retire_c = (state_q == S_RUN) && !Start && !Ack && taken_c;
        taken_d        = taken_q;
        if (clear_c) begin
            taken_d = '0;
        end else if (taken_retire_c && (taken_q != '1)) begin
            taken_d = taken_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) taken_q <= '0;
        else       taken_q <= taken_d;
    end

    assign TakenCount = taken_q;
`else
    assign TakenCount = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: vector table through a scoreboard queue plus reset/halt/wrap sequences.
module tb_pc_fetch_unit;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned CNT_W = 16;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic             Ack;
    logic             JumpEqual;
    logic             JumpNotEqual;
    logic             OffsetEn;
    logic [1:0]       PCRegSelect;
    logic             ZeroFlag;
    logic [PC_W-1:0]  ProgCtr;
    logic             Running;
    logic             Done;
    logic [CNT_W-1:0] InstCount;
    logic [CNT_W-1:0] TakenCount;

    pc_fetch_unit #(.PC_W(PC_W), .OFFSET_AMT(16), .CNT_W(CNT_W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Ack          (Ack),
        .JumpEqual    (JumpEqual),
        .JumpNotEqual (JumpNotEqual),
        .OffsetEn     (OffsetEn),
        .PCRegSelect  (PCRegSelect),
        .ZeroFlag     (ZeroFlag),
        .ProgCtr      (ProgCtr),
        .Running      (Running),
        .Done         (Done),
        .InstCount    (InstCount),
        .TakenCount   (TakenCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       start;
        logic       ack;
        logic       je;
        logic       jne;
        logic       off;
        logic [1:0] sel;
        logic       z;
        int         pc;
        int         run;
        int         done;
        int         inst;
        int         tk;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   step   = 0;

    function automatic int exp_tk(input int t);
`ifdef PC_FETCH_BRANCH_COUNT_EN
        return t;
`else
        return 0 * t;
`endif
    endfunction

    function automatic vec_t mk(input logic st, input logic ak, input logic je, input logic jne,
                                input logic off, input logic [1:0] sel, input logic z,
                                input int pc, input int run, input int done, input int inst, input int tk);
        vec_t v;
        v.start = st; v.ack = ak; v.je = je; v.jne = jne; v.off = off; v.sel = sel; v.z = z;
        v.pc = pc; v.run = run; v.done = done; v.inst = inst; v.tk = tk;
        return v;
    endfunction

    function automatic vec_t nop(input int pc, input int inst, input int tk);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, pc, 1, 0, inst, tk);
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s step %0d: got %0d want %0d", nm, step, got, want);
        end
    endtask

    task automatic check_all(input vec_t e);
        chk("ProgCtr",    int'(ProgCtr),    e.pc);
        chk("Running",    int'(Running),    e.run);
        chk("Done",       int'(Done),       e.done);
        chk("InstCount",  int'(InstCount),  e.inst);
        chk("TakenCount", int'(TakenCount), exp_tk(e.tk));
    endtask

    // Drive on the falling edge, compare the scoreboard head just after the rising edge
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge Clk);
        Start = v.start; Ack = v.ack; JumpEqual = v.je; JumpNotEqual = v.jne;
        OffsetEn = v.off; PCRegSelect = v.sel; ZeroFlag = v.z;
        sb_q.push_back(v);
        @(posedge Clk);
        #1;
        e = sb_q.pop_front();
        step++;
        check_all(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        Reset = 1'b1; Start = 1'b1; Ack = 1'b0; JumpEqual = 1'b0; JumpNotEqual = 1'b0;
        OffsetEn = 1'b0; PCRegSelect = 2'b00; ZeroFlag = 1'b0;
        #2;
        check_all(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge Clk);
        Reset = 1'b0;

        // Start handshake, spc/jne on PCreg1, spc+offset/je on PCreg3
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
        tbl.push_back(nop(0, 0, 0));
        for (int i = 1; i <= 5; i++) tbl.push_back(nop(i, i, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b01, 0, 6, 1, 0, 6, 0));
        tbl.push_back(nop(7, 7, 0));
        tbl.push_back(nop(8, 8, 0));
        tbl.push_back(nop(9, 9, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 2'b01, 0, 6, 1, 0, 10, 1));
        tbl.push_back(nop(7, 11, 1));
        tbl.push_back(nop(8, 12, 1));
        tbl.push_back(nop(9, 13, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 2'b01, 1, 10, 1, 0, 14, 1));
        for (int k = 0; k < 10; k++) tbl.push_back(nop(11 + k, 15 + k, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2'b11, 0, 21, 1, 0, 25, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 2'b11, 1, 36, 1, 0, 26, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 2'b00, 1, 37, 1, 0, 27, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 2'b11, 0, 38, 1, 0, 28, 2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 2'b01, 1, 6, 1, 0, 29, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b10, 0, 7, 1, 0, 30, 3));
        tbl.push_back(mk(0, 0, 0, 1, 0, 2'b10, 0, 7, 1, 0, 31, 4));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Halt on Ack at PC=50, hold, then Start+Ack returns to IDLE
        apply(nop(0, 0, 0));
        for (int i = 1; i <= 50; i++) apply(nop(i, i, 0));
        apply(mk(0, 1, 0, 0, 0, 2'b00, 0, 50, 0, 1, 51, 0));
        apply(mk(0, 0, 0, 0, 0, 2'b00, 0, 50, 0, 1, 51, 0));
        apply(mk(0, 1, 0, 0, 0, 2'b00, 0, 50, 0, 1, 51, 0));
        apply(mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));

        // Asynchronous reset while running at PC=37
        apply(nop(0, 0, 0));
        for (int i = 1; i <= 37; i++) apply(nop(i, i, 0));
        apply(mk(0, 0, 0, 1, 0, 2'b01, 0, 0, 1, 0, 38, 1));
        for (int i = 1; i <= 37; i++) apply(nop(i, 38 + i, 1));
        @(negedge Clk);
        Start = 1'b1;
        Reset = 1'b1;
        #1;
        step++;
        check_all(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge Clk);
        Reset = 1'b0;

        // PC wrap at 1023 and wrapped spc+offset target at 1020
        apply(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
        apply(nop(0, 0, 0));
        for (int i = 1; i <= 1020; i++) apply(nop(i, i, 0));
        apply(mk(0, 0, 0, 0, 1, 2'b01, 0, 1021, 1, 0, 1021, 0));
        apply(nop(1022, 1022, 0));
        apply(nop(1023, 1023, 0));
        apply(nop(0, 1024, 0));
        apply(mk(0, 0, 0, 1, 0, 2'b01, 0, 12, 1, 0, 1025, 1));
        v = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        apply(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
